// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv -- iterative RV32M multiply/divide unit for the EX stage.
//
// One M-extension instruction is accepted from ID/EX, its operands are
// reduced to magnitudes, and a 32-step shift-add multiply or restoring divide
// runs one step per clock. The sign of the final result is restored when the
// last step completes. Divide-by-zero and signed overflow skip the iteration
// and finish one cycle after acceptance.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      synchronous active-high reset
//   valid_i  current EX instruction is an M-extension op
//   funct3   RV32M op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1/rs2  forwarded source operands
//   hold     downstream stall: keep the finished result presented
//   flush    squash the instruction currently in EX
//   stall    hold ID/EX and upstream registers
//   done     result valid this cycle
//   result   op result, valid while done=1
// ----------------------------------------------------------------------------
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             hold,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [4:0]       LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [4:0] cnt_q;

    // Operation context captured at accept; ignored inputs afterwards.
    logic [2:0]         op_q;
    logic               neg_q;
    logic [WIDTH-1:0]   opb_q;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;     // product, or dividend/quotient in low half
    logic [WIDTH:0]     rem_q;     // partial remainder
    logic [WIDTH-1:0]   result_q;

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_dw(input logic [2*WIDTH-1:0] v);
        return (~v) + (2*WIDTH)'(1);
    endfunction

    // ---------------------------------------------------------------- accept
    logic             accept;
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             is_div, div_zero, div_ovf, special;
    logic             sign_d;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        accept   = (state_q == S_IDLE) && valid_i && !flush;
        is_div   = funct3[2];
        // Divides: bit0 clear means signed. Multiplies: MULHU has both
        // unsigned, MULHSU only rs2 unsigned.
        a_signed = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = is_div ? !funct3[0] : !funct3[1];
        a_neg    = a_signed && rs1[WIDTH-1];
        b_neg    = b_signed && rs2[WIDTH-1];
        a_mag    = a_neg ? negate_w(rs1) : rs1;
        b_mag    = b_neg ? negate_w(rs2) : rs2;

        div_zero = is_div && (rs2 == '0);
        div_ovf  = is_div && !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
        special  = div_zero || div_ovf;

        // Remainder takes the dividend's sign; everything else the XOR.
        sign_d   = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);

        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? rs1 : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // ------------------------------------------------------------- iteration
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH+1:0]   rem_sh, rem_diff;
    logic               q_bit;
    logic [WIDTH:0]     rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

    always_comb begin
        // Shift-add: low half holds the remaining multiplier bits, the
        // carry out of the add drops into the top as everything shifts right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
        mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: bring in the next dividend bit, try the subtract,
        // keep it only if it did not go negative.
        rem_sh   = {rem_q, acc_q[WIDTH-1]};
        rem_diff = rem_sh - {2'b00, opb_q};
        q_bit    = !rem_diff[WIDTH+1];
        rem_nxt  = q_bit ? rem_diff[WIDTH:0] : rem_sh[WIDTH:0];
        quo_nxt  = {acc_q[WIDTH-2:0], q_bit};

        // Sign correction uses the values produced by the final step.
        prod_fix = neg_q ? negate_dw(mul_nxt) : mul_nxt;
        quo_fix  = neg_q ? negate_w(quo_nxt) : quo_nxt;
        rem_fix  = neg_q ? negate_w(rem_nxt[WIDTH-1:0]) : rem_nxt[WIDTH-1:0];

        case (op_q)
            3'b000:                 final_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    // --------------------------------------------------------- control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept || (state_q == S_BUSY && flush)) begin
                cnt_q <= '0;
            end else if (state_q == S_BUSY) begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = special ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || !hold) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        stall = !rst && (accept || (state_q == S_BUSY));
        done  = (state_q == S_DONE);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= funct3;
            neg_q <= sign_d;
            opb_q <= b_mag;
            acc_q <= {{WIDTH{1'b0}}, a_mag};
            rem_q <= '0;
        end else if (state_q == S_BUSY) begin
            acc_q <= op_q[2] ? {acc_q[2*WIDTH-1:WIDTH], quo_nxt} : mul_nxt;
            rem_q <= rem_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else if (accept && special) begin
            result_q <= special_res;
        end else if (state_q == S_BUSY && cnt_q == LAST_ITER && !flush) begin
            result_q <= final_res;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        hold;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .funct3  (funct3),
        .rs1     (rs1),
        .rs2     (rs2),
        .hold    (hold),
        .flush   (flush),
        .stall   (stall),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, outputs are sampled at 2.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input string tag);
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        funct3  = f3;
        rs1     = a;
        rs2     = b;
        #1;
        check({tag, "_stall_T"}, 32'(stall), 32'd1);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        funct3  = 3'($urandom);
        rs1     = $urandom;
        rs2     = $urandom;
        #1;
    endtask

    // Counts cycles after acceptance until done, scrambling operands meanwhile.
    task automatic wait_done(input string tag, output int lat);
        int bad;
        bad = 0;
        lat = 1;
        while (!done && lat < 40) begin
            if (!stall) bad++;
            @(posedge clk);
            #1;
            funct3 = 3'($urandom);
            rs1    = $urandom;
            rs2    = $urandom;
            #1;
            lat++;
        end
        check({tag, "_busy_stall"}, 32'(bad), 32'd0);
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string tag);
        int lat;
        start_op(f3, a, b, tag);
        wait_done(tag, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp);
        check({tag, "_done_stall"}, 32'(stall), 32'd0);
        @(posedge clk);
        #2;
        check({tag, "_done_clear"}, 32'(done), 32'd0);
    endtask

    task automatic scan_no_done(input string tag);
        int n;
        n = 0;
        repeat (40) begin
            @(posedge clk);
            #2;
            if (done) n++;
        end
        check({tag, "_no_done"}, 32'(n), 32'd0);
    endtask

    initial begin
        int lat;
        rst     = 1'b1;
        valid_i = 1'b1;
        funct3  = OP_MUL;
        rs1     = 32'd0;
        rs2     = 32'd0;
        hold    = 1'b0;
        flush   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        rst     = 1'b0;
        valid_i = 1'b0;
        @(posedge clk);
        #2;
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_idle_stall", 32'(stall), 32'd0);

        // Multiplies
        do_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        do_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
        do_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, "mulhsu");

        // Divides
        do_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div");
        do_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem");
        do_op(OP_DIVU,   32'd100,       32'd7,         32'd14,        33, "divu");
        do_op(OP_REMU,   32'd100,       32'd7,         32'd2,         33, "remu");

        // Special cases
        do_op(OP_DIVU,   32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1,  "divu_zero");
        do_op(OP_REM,    32'h1234_5678, 32'd0,         32'h1234_5678, 1,  "rem_zero");
        do_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
        do_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf");

        // Hold in DONE for 3 cycles
        start_op(OP_MUL, 32'd6, 32'd7, "hold");
        wait_done("hold", lat);
        check("hold_latency", 32'(lat), 32'd33);
        check("hold_result", result, 32'd42);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check("hold_done_kept", 32'(done), 32'd1);
            check("hold_result_kept", result, 32'd42);
        end
        hold = 1'b0;
        do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, "after_hold");

        // Flush mid-BUSY at T+10
        start_op(OP_MUL, 32'd5, 32'd6, "flush");
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_busy_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        scan_no_done("flush");
        check("flush_result_kept", result, 32'd1);

        // Flush in IDLE blocks acceptance
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        flush   = 1'b1;
        funct3  = OP_DIVU;
        rs1     = 32'd9;
        rs2     = 32'd0;
        #1;
        check("idle_flush_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush   = 1'b0;
        scan_no_done("idle_flush");

        // Reset mid-operation at T+5
        start_op(OP_DIVU, 32'd100, 32'd7, "rst_mid");
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_stall_after", 32'(stall), 32'd0);
        check("rst_mid_result", result, 32'd0);
        scan_no_done("rst_mid");

        // Unit is usable again after the mid-operation reset
        do_op(OP_REMU, 32'd100, 32'd7, 32'd2, 33, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It consumes the ID/EX register outputs: the decoded M-op valid, funct3 and the forwarded rs1/rs2 values. It runs one 32-cycle shift-add or restoring-divide sequence per instruction. While busy it drives stall back to the ID/EX and upstream registers, and it presents a one-cycle result to the EX/MEM register.

Parameters:
WIDTH, 32, operand/result width (only 32 supported; RV32M)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
valid_i  input  1  current EX instruction is an M-extension op
funct3  input  3  RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  WIDTH  forwarded source operand 1
rs2  input  WIDTH  forwarded source operand 2
hold  input  1  downstream stall (EX/MEM cannot accept)
flush  input  1  squash the instruction currently in EX
stall  output  1  hold ID/EX and upstream registers
done  output  1  result valid this cycle
result  output  WIDTH  op result, valid when done=1

Behaviour:
- State machine IDLE / BUSY / DONE, plus a 5-bit iteration counter. Reset (synchronous, rst=1 at edge) forces IDLE, counter=0, result=0, done=0. stall is 0 while rst=1.
- Accept: IDLE && valid_i && !flush at edge ending cycle T.
  - Latch funct3, rs1 and rs2 into internal registers. Later changes on rs1/rs2/funct3 are ignored until IDLE.
  - Normal path: IDLE->BUSY, counter=0.
  - Special-case path: IDLE->DONE directly.
- Operand prep on accept: take magnitudes per op signedness.
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Record result sign:
  - Product sign = XOR of operand signs (signed operands only).
  - Quotient sign = XOR of operand signs.
  - Remainder sign = dividend sign.
- BUSY: one iteration per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
  - Counter increments each cycle. When counter==31, go to DONE and apply sign correction into result.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Special cases (1-cycle path, result computed at accept):
  - Divisor 0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = rs1.
  - Signed overflow, DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: result 0x80000000. REM with same operands: result 0.
- Timing, normal path: stall=1 in cycles T..T+32, done=1 and stall=0 in cycle T+33. Total 34 cycles occupancy.
- Timing, special path: stall=1 in T, done=1 in T+1.
- stall = (IDLE && valid_i && !flush) || BUSY. It is 0 in DONE.
- DONE:
  - done=1 and result is held stable.
  - If hold=1, remain in DONE with result unchanged and done staying 1. No re-accept of the same instruction.
  - If hold=0, go to IDLE next cycle. The next valid_i is then a new instruction; back-to-back ops start one cycle after DONE.
- flush in BUSY or DONE: go to IDLE next edge. done is 0 from that next cycle. No result is produced.
- flush in IDLE with valid_i: no accept, stall=0.
- valid_i=0 in IDLE: stall=0, done=0, result keeps its last value.
- rst mid-operation overrides everything: IDLE next cycle, partial state discarded.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, accepted cycle T -> stall high T..T+32; done only at T+33 with result 0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each done at T+33.
- DIVU 0x12345678 / 0 -> 0xFFFFFFFF, done at T+1. REM same -> 0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Change rs1/rs2 mid-BUSY -> result unaffected. flush at T+10 -> IDLE at T+11, no done pulse, stall 0. rst at T+5 -> IDLE, done 0.
- hold=1 for 3 cycles from the DONE cycle -> done and result stable 4 cycles. Then next MUL valid on the cycle after IDLE -> accepted, new 34-cycle sequence.
